// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the 256-byte instruction memory: packs little-endian
// words, writes them to consecutive word addresses and holds the core until done.
module instr_mem_loader #(
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  n_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [7:0]  wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold
);

    localparam int unsigned LEN_W = 7;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, idx_q, len_clamped;
    logic [CNT_W-1:0]   cnt_q;
    logic               load, accept, last_word;

    assign len_clamped = (n_words > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : n_words;
    assign load        = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept      = (state_q == RECV) && byte_valid;
    assign last_word   = (idx_q == (len_q - LEN_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        we         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (cnt_q == CNT_W'(3))) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                we      = 1'b1;
                busy    = 1'b1;
                state_d = last_word ? DONE : RECV;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    state_d = (len_clamped == '0) ? DONE : RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word assembly, word index and write address
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            wa    <= '0;
            wd    <= '0;
        end else begin
            if (load) begin
                len_q <= len_clamped;
                idx_q <= '0;
                cnt_q <= '0;
            end
            if (accept) begin
                wd[{cnt_q, 3'b000} +: 8] <= byte_data;
                cnt_q                    <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    wa <= 8'({idx_q, 2'b00});
                end
            end
            if ((state_q == WRITE) && !last_word) begin
                idx_q <= idx_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: randomized byte streams, expected writes
// and timed status expectations queued by stimulus, checked by a monitor.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [6:0]  n_words;
    logic [7:0]  byte_data;
    logic        byte_ready, we, busy, done, cpu_hold;
    logic [7:0]  wa;
    logic [31:0] wd;

    instr_mem_loader #(.MAX_WORDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .n_words(n_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int F_DONE = 0, F_HOLD = 1, F_BUSY = 2, F_READY = 3, F_WE = 4, F_WA = 5, F_WD = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    typedef struct { int c; int f; logic [31:0] v; string name; } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  checks = 0, failures = 0, we_count = 0;
    int  exp_total = 0, timeouts = 0;
    bit  finish_req = 1'b0;

    function automatic logic [31:0] fieldval(int f);
        case (f)
            F_DONE:  return 32'(done);
            F_HOLD:  return 32'(cpu_hold);
            F_BUSY:  return 32'(busy);
            F_READY: return 32'(byte_ready);
            F_WE:    return 32'(we);
            F_WA:    return 32'(wa);
            default: return wd;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on every write, timed expectations, invariants
    always @(negedge clk) begin
        wr_t w;
        if (!rst && we) begin
            we_count++;
            if (wq.size() == 0) begin
                chk("unexpected_we", 32'(we), 32'd0);
            end else begin
                w = wq.pop_front();
                chk("wa", 32'(wa), 32'(w.a));
                chk("wd", wd, w.d);
            end
        end
        if (!rst) begin
            chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
            chk("ready_vs_busy", 32'(byte_ready), 32'(busy && !we));
        end
        for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].c == cyc) begin
                chk(sq[i].name, fieldval(sq[i].f), sq[i].v);
                sq.delete(i);
            end else if (sq[i].c < cyc) begin
                chk({"missed_", sq[i].name}, 32'(cyc), 32'(sq[i].c));
                sq.delete(i);
            end
        end
        if (finish_req || cyc > 40000) begin
            chk("feed_timeouts", 32'(timeouts), 32'd0);
            chk("watchdog", 32'(cyc > 40000), 32'd0);
            chk("scoreboard_empty", 32'(wq.size()), 32'd0);
            chk("status_empty", 32'(sq.size()), 32'd0);
            chk("we_count", 32'(we_count), 32'(exp_total));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic expect_at(int c, int f, logic [31:0] v, string name);
        st_t s;
        s.c = c; s.f = f; s.v = v; s.name = name;
        sq.push_back(s);
    endtask

    // Reference model: first min(n,64) words, little-endian, at word addresses 0,4,8,...
    task automatic push_load(int n, bq_t b);
        int len;
        wr_t w;
        len = (n > 64) ? 64 : n;
        for (int i = 0; i < len; i++) begin
            w.a = 8'(i * 4);
            w.d = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            wq.push_back(w);
            exp_total++;
        end
    endtask

    task automatic gen_bytes(int nbytes, output bq_t q);
        q = {};
        for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom));
    endtask

    // Returns t = index of the edge that samples start (cyc value right after it)
    task automatic do_start(int n, output int t);
        @(posedge clk); #1;
        start = 1'b1; n_words = 7'(n);
        @(posedge clk); #1;
        start = 1'b0;
        t = cyc;
    endtask

    // mode 0: back-to-back, 1: valid toggles 1,0,1,0, 2: random gaps
    task automatic feed(bq_t q, int mode, int start_pulse_at = -1);
        int  i = 0, c = 0;
        bit  acc;
        while (i < q.size()) begin
            if (c > 2000) begin
                timeouts++;
                break;
            end
            case (mode)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (c % 2 == 0);
                default: byte_valid = ($urandom_range(0, 2) != 0);
            endcase
            byte_data = q[i];
            start     = (c == start_pulse_at);
            if (c == start_pulse_at) n_words = 7'd5;
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
            c++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        bq_t b, b2;
        int  t, e, n, mode;
        rst = 1'b1; start = 1'b0; n_words = '0; byte_valid = 1'b0; byte_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        t = cyc;
        expect_at(t, F_READY, 0, "rst_byte_ready");
        expect_at(t, F_WE,    0, "rst_we");
        expect_at(t, F_WA,    0, "rst_wa");
        expect_at(t, F_WD,    0, "rst_wd");
        expect_at(t, F_BUSY,  0, "rst_busy");
        expect_at(t, F_DONE,  0, "rst_done");
        expect_at(t, F_HOLD,  1, "rst_cpu_hold");
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-word load, back-to-back
        b = {8'h93, 8'h00, 8'h70, 8'h00, 8'h93, 8'h01, 8'h30, 8'h00};
        push_load(2, b);
        do_start(2, t);
        expect_at(t,     F_READY, 1, "two_ready_first");
        expect_at(t,     F_HOLD,  1, "two_hold");
        expect_at(t + 4, F_WE,    1, "two_first_we");
        expect_at(t + 9, F_WA,    32'h04, "two_last_wa");
        expect_at(t + 10, F_DONE, 1, "two_done");
        expect_at(t + 10, F_HOLD, 0, "two_release");
        feed(b, 0);
        repeat (3) @(posedge clk);

        // Backpressure
        push_load(2, b);
        do_start(2, t);
        feed(b, 1);
        e = cyc;
        expect_at(e,     F_WE,   1, "bp_last_we");
        expect_at(e + 1, F_DONE, 1, "bp_done");
        repeat (3) @(posedge clk);

        // Zero length
        do_start(0, t);
        expect_at(t, F_DONE, 1, "zero_done");
        expect_at(t, F_BUSY, 0, "zero_busy");
        expect_at(t, F_HOLD, 0, "zero_hold");
        repeat (3) @(posedge clk);

        // Clamp: 100 requested, 64 written
        gen_bytes(256, b);
        push_load(100, b);
        do_start(100, t);
        expect_at(t + 320, F_DONE, 1, "clamp_done_time");
        feed(b, 0);
        e = cyc;
        expect_at(e,     F_WA,    32'hFC, "clamp_last_wa");
        expect_at(e,     F_READY, 0, "clamp_ready_after_256");
        expect_at(e + 1, F_READY, 0, "clamp_ready_done");
        repeat (3) @(posedge clk);

        // Reset mid-word
        gen_bytes(2, b);
        do_start(1, t);
        feed(b, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        t = cyc;
        expect_at(t, F_WE,   0, "midrst_we");
        expect_at(t, F_WA,   0, "midrst_wa");
        expect_at(t, F_WD,   0, "midrst_wd");
        expect_at(t, F_HOLD, 1, "midrst_hold");
        expect_at(t, F_BUSY, 0, "midrst_busy");
        gen_bytes(4, b2);
        push_load(1, b2);
        do_start(1, t);
        feed(b2, 0);
        repeat (3) @(posedge clk);

        // Start while busy is ignored, then reload from DONE
        gen_bytes(8, b);
        push_load(2, b);
        do_start(2, t);
        expect_at(t + 10, F_DONE, 1, "busy_start_done");
        feed(b, 0, 3);
        gen_bytes(4, b2);
        push_load(1, b2);
        do_start(1, t);
        expect_at(t,     F_HOLD, 1, "reload_hold");
        expect_at(t,     F_DONE, 0, "reload_done_low");
        expect_at(t,     F_BUSY, 1, "reload_busy");
        expect_at(t + 5, F_DONE, 1, "reload_done");
        feed(b2, 0);
        repeat (3) @(posedge clk);

        // Randomized loads with random gap patterns
        for (int k = 0; k < 6; k++) begin
            n    = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            gen_bytes(4 * n, b);
            push_load(n, b);
            do_start(n, t);
            feed(b, mode);
            e = cyc;
            expect_at(e,     F_WE,   1, "rand_last_we");
            expect_at(e + 1, F_DONE, 1, "rand_done");
            repeat (2) @(posedge clk);
        end

        finish_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_did_not_finish actual=running required=finished");
        $fatal(1, "monitor did not terminate");
    end

endmodule
